// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone round-robin arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    localparam int DEFAULT_TIMEOUT = 255;

    function automatic logic [1:0] state_to_gnt(input arb_state_e state);
        logic [1:0] gnt;
        case (state)
            OWN0:    gnt = GNT_M0;
            OWN1:    gnt = GNT_M1;
            default: gnt = GNT_NONE;
        endcase
        return gnt;
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Wait-state watchdog: counts stalled strobe cycles and pulses expire when the
// count reaches TIMEOUT. TIMEOUT of 0 disables it entirely.
module wb_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int            CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT   = CW'(TIMEOUT);
    localparam logic          ENABLED = (TIMEOUT != 0);

    logic [CW-1:0] cnt_r;

    // Expiry only counts when this cycle would otherwise keep counting.
    always_comb begin
        expire = ENABLED & en & ~clr & (cnt_r == LIMIT);
    end

    // Stall counter; restarts after every expiry so the pulse is one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr || expire || !ENABLED) begin
            cnt_r <= {CW{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of a single slave, with
// cycle-long ownership, owner-only response steering and a hung-transfer watchdog.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic [DW-1:0]   m0_dat_o,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic [DW-1:0]   m1_dat_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    input  logic            s_ack_i,
    input  logic [DW-1:0]   s_dat_i,
    output logic [1:0]      gnt_o
);

    localparam int SW = DW / 8;

    arb_state_e state_r;
    arb_state_e state_next_s;
    logic       last_gnt_r;
    logic       last_gnt_next_s;
    logic       req0_s;
    logic       req1_s;
    logic       owned_s;
    logic       own_stb_s;
    logic       wd_clr_s;
    logic       wd_en_s;
    logic       wd_expire_s;

    assign req0_s  = m0_cyc_i & m0_stb_i;
    assign req1_s  = m1_cyc_i & m1_stb_i;
    assign owned_s = (state_r != IDLE);
    assign gnt_o   = state_to_gnt(state_r);

    // Next-state: ties go to the master that did not own the bus last.
    always_comb begin
        state_next_s    = state_r;
        last_gnt_next_s = last_gnt_r;
        case (state_r)
            IDLE: begin
                if (req0_s && req1_s) begin
                    state_next_s = last_gnt_r ? OWN0 : OWN1;
                end else if (req0_s) begin
                    state_next_s = OWN0;
                end else if (req1_s) begin
                    state_next_s = OWN1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            OWN0: begin
                if (!m0_cyc_i) begin
                    state_next_s    = IDLE;
                    last_gnt_next_s = 1'b0;
                end else begin
                    state_next_s = OWN0;
                end
            end
            OWN1: begin
                if (!m1_cyc_i) begin
                    state_next_s    = IDLE;
                    last_gnt_next_s = 1'b1;
                end else begin
                    state_next_s = OWN1;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Grant state and round-robin history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            last_gnt_r <= 1'b1;
        end else begin
            state_r    <= state_next_s;
            last_gnt_r <= last_gnt_next_s;
        end
    end

    // Request mux: only the registered owner reaches the slave.
    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_sel_o   = {SW{1'b0}};
        s_adr_o   = {AW{1'b0}};
        s_dat_o   = {DW{1'b0}};
        own_stb_s = 1'b0;
        case (state_r)
            OWN0: begin
                s_cyc_o   = m0_cyc_i;
                s_stb_o   = m0_stb_i;
                s_we_o    = m0_we_i;
                s_sel_o   = m0_sel_i;
                s_adr_o   = m0_adr_i;
                s_dat_o   = m0_dat_i;
                own_stb_s = m0_stb_i;
            end
            OWN1: begin
                s_cyc_o   = m1_cyc_i;
                s_stb_o   = m1_stb_i;
                s_we_o    = m1_we_i;
                s_sel_o   = m1_sel_i;
                s_adr_o   = m1_adr_i;
                s_dat_o   = m1_dat_i;
                own_stb_s = m1_stb_i;
            end
            default: begin
                own_stb_s = 1'b0;
            end
        endcase
    end

    // A transfer aborted by reset must not see a late ack or error.
    always_comb begin
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_dat_o = {DW{1'b0}};
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_dat_o = {DW{1'b0}};
        case (state_r)
            OWN0: begin
                m0_ack_o = s_ack_i & ~rst;
                m0_err_o = wd_expire_s & ~rst;
                m0_dat_o = s_dat_i;
            end
            OWN1: begin
                m1_ack_o = s_ack_i & ~rst;
                m1_err_o = wd_expire_s & ~rst;
                m1_dat_o = s_dat_i;
            end
            default: begin
                m0_ack_o = 1'b0;
            end
        endcase
    end

    assign wd_clr_s = ~owned_s | (state_next_s != state_r) | s_ack_i | ~own_stb_s;
    assign wd_en_s  = owned_s & own_stb_s & ~s_ack_i;

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr_s),
        .en     (wd_en_s),
        .expire (wd_expire_s)
    );

endmodule
